// File: rtl/mips_data_mem_if.sv
// Request/response bus of the MIPS data memory.
// master drives requests; slave answers with a one-cycle rvalid pulse.
// Request is valid only while ready=1; there is no other back-pressure.
interface mips_data_mem_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        ready;
    logic        rvalid;
    logic [31:0] read_data;
    logic        err;

    modport slave (
        input  req, we, size, sign_ext, address, write_data,
        output ready, rvalid, read_data, err
    );

    modport master (
        output req, we, size, sign_ext, address, write_data,
        input  ready, rvalid, read_data, err
    );
endinterface

// File: rtl/mips_data_mem.sv
// Byte-addressed MIPS data memory: byte/halfword/word loads and stores, fault detection.
// Latency: response (rvalid/read_data/err) one cycle after an accepted request.
// Backpressure: ready=0 only during the DEPTH-cycle INIT clear; in RUN every request is taken.
module mips_data_mem #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           startin,
    mips_data_mem_if.slave bus
);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_q, clr_d;
    logic            ready;

    logic [31:0]     mem_q [DEPTH];

    logic            rvalid_q, rvalid_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            accept;
    logic            fault;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic [3:0]      wbe;
    logic [31:0]     wdat;
    logic [31:0]     word_v;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     ld_val;

    // State register and clear counter; reset always restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (!startin) begin
            state_q <= INIT;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // Next state: INIT walks every word index once, then RUN forever.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        ready   = 1'b0;
        case (state_q)
            INIT: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    clr_d   = '0;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: state_d = INIT;
        endcase
    end

    assign bus.ready = ready;
    assign accept    = bus.req && ready;
    assign idx       = bus.address[AW+1:2];
    assign lane      = bus.address[1:0];

    // Request decode: fault checks, store lane enables and lane-replicated store data.
    always_comb begin
        fault = (bus.address >= 32'(4 * DEPTH));
        wbe   = 4'b0000;
        wdat  = bus.write_data;
        case (bus.size)
            2'b00: begin
                wbe  = 4'b0001 << lane;
                wdat = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                if (lane[0]) fault = 1'b1;
                wbe  = lane[1] ? 4'b1100 : 4'b0011;
                wdat = {2{bus.write_data[15:0]}};
            end
            2'b10: begin
                if (lane != 2'b00) fault = 1'b1;
                wbe  = 4'b1111;
            end
            default: fault = 1'b1;
        endcase
    end

    // Load formatting: pick the addressed lane(s), right-align, extend.
    always_comb begin
        word_v = mem_q[idx];
        byte_v = 8'(word_v >> {lane, 3'b000});
        half_v = lane[1] ? word_v[31:16] : word_v[15:0];
        case (bus.size)
            2'b00:   ld_val = bus.sign_ext ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            2'b01:   ld_val = bus.sign_ext ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            default: ld_val = word_v;
        endcase
    end

    // Response next-state: data only for good loads, zeros otherwise.
    always_comb begin
        rvalid_d = accept;
        err_d    = accept && fault;
        rdata_d  = '0;
        if (accept && !fault && !bus.we) rdata_d = ld_val;
    end

    // Response registers; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (!startin) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.rvalid    = rvalid_q;
    assign bus.err       = err_q;
    assign bus.read_data = rdata_q;

    // Memory array: INIT zeroes one word per cycle, RUN applies good stores lane by lane.
    always_ff @(posedge clk) begin
        if (startin) begin
            if (state_q == INIT) begin
                mem_q[clr_q] <= '0;
            end else if (accept && bus.we && !fault) begin
                for (int k = 0; k < 4; k++) begin
                    if (wbe[k]) mem_q[idx][8*k +: 8] <= wdat[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed self-checking bench for mips_data_mem (DEPTH=64).
// Inputs change just after the falling edge; outputs are checked on the falling edge.
// Every request helper checks the response of the request it just issued.
module tb_mips_data_mem;

    logic clk = 1'b0;
    logic startin;
    int   n_chk  = 0;
    int   n_fail = 0;

    mips_data_mem_if bus ();

    mips_data_mem #(.DEPTH(64)) dut (
        .clk     (clk),
        .startin (startin),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req        = 1'b1;
        bus.we         = w;
        bus.size       = sz;
        bus.sign_ext   = sx;
        bus.address    = a;
        bus.write_data = wd;
    endtask

    // Issue one request, wait one cycle, check its response.
    task automatic access(input string tag, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_rd);
        drive(w, sz, sx, a, wd);
        @(negedge clk);
        bus.req = 1'b0;
        chk({tag, ".rvalid"}, {31'b0, bus.rvalid}, 32'd1);
        chk({tag, ".err"},    {31'b0, bus.err},    {31'b0, e_err});
        chk({tag, ".data"},   bus.read_data,       e_rd);
    endtask

    // Walk the 64 INIT cycles (the first is the current one), then expect ready.
    task automatic init_phase(input string tag);
        chk({tag, ".ready0"},  {31'b0, bus.ready},  32'd0);
        chk({tag, ".rvalid0"}, {31'b0, bus.rvalid}, 32'd0);
        for (int i = 2; i <= 64; i++) begin
            @(negedge clk);
            chk({tag, ".ready"},  {31'b0, bus.ready},  32'd0);
            chk({tag, ".rvalid"}, {31'b0, bus.rvalid}, 32'd0);
        end
        @(negedge clk);
        chk({tag, ".ready65"}, {31'b0, bus.ready}, 32'd1);
    endtask

    initial begin
        startin        = 1'b0;
        bus.req        = 1'b0;
        bus.we         = 1'b0;
        bus.size       = 2'b10;
        bus.sign_ext   = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.ready",  {31'b0, bus.ready},  32'd0);
        chk("rst.rvalid", {31'b0, bus.rvalid}, 32'd0);
        chk("rst.err",    {31'b0, bus.err},    32'd0);
        chk("rst.data",   bus.read_data,       32'd0);

        // Init: release reset with a load held on the bus the whole time
        startin = 1'b1;
        drive(1'b0, 2'b10, 1'b0, 32'h0FC, 32'h0);
        init_phase("init");
        access("init_ld0fc", 1'b0, 2'b10, 1'b0, 32'h0FC, 32'h0, 1'b0, 32'h0000_0000);

        // Word store and back-to-back load
        access("sw004", 1'b1, 2'b10, 1'b0, 32'h004, 32'hCAFE_BABE, 1'b0, 32'h0);
        access("lw004", 1'b0, 2'b10, 1'b0, 32'h004, 32'h0,         1'b0, 32'hCAFE_BABE);

        // Sub-word accesses
        access("sb006",    1'b1, 2'b00, 1'b0, 32'h006, 32'hFFFF_FF80, 1'b0, 32'h0);
        access("lw004b",   1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 1'b0, 32'hCA80_BABE);
        access("lb006",    1'b0, 2'b00, 1'b1, 32'h006, 32'h0, 1'b0, 32'hFFFF_FF80);
        access("lbu006",   1'b0, 2'b00, 1'b0, 32'h006, 32'h0, 1'b0, 32'h0000_0080);
        access("lh006",    1'b0, 2'b01, 1'b1, 32'h006, 32'h0, 1'b0, 32'hFFFF_CA80);
        access("lhu004",   1'b0, 2'b01, 1'b0, 32'h004, 32'h0, 1'b0, 32'h0000_BABE);
        access("lh004",    1'b0, 2'b01, 1'b1, 32'h004, 32'h0, 1'b0, 32'hFFFF_BABE);
        access("lb007",    1'b0, 2'b00, 1'b1, 32'h007, 32'h0, 1'b0, 32'hFFFF_FFCA);
        access("lbu005",   1'b0, 2'b00, 1'b0, 32'h005, 32'h0, 1'b0, 32'h0000_00BA);
        access("lw004sx",  1'b0, 2'b10, 1'b1, 32'h004, 32'h0, 1'b0, 32'hCA80_BABE);
        access("sh00a",    1'b1, 2'b01, 1'b0, 32'h00A, 32'hAAAA_1234, 1'b0, 32'h0);
        access("lw008",    1'b0, 2'b10, 1'b0, 32'h008, 32'h0, 1'b0, 32'h1234_0000);
        access("sb009",    1'b1, 2'b00, 1'b0, 32'h009, 32'h0000_0077, 1'b0, 32'h0);
        access("lw008b",   1'b0, 2'b10, 1'b0, 32'h008, 32'h0, 1'b0, 32'h1234_7700);

        // Faults: no data, err set, memory untouched
        access("f_sw002",  1'b1, 2'b10, 1'b0, 32'h002, 32'hFFFF_FFFF, 1'b1, 32'h0);
        access("f_lh005",  1'b0, 2'b01, 1'b1, 32'h005, 32'h0,         1'b1, 32'h0);
        access("f_lw100",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0,         1'b1, 32'h0);
        access("f_sb100",  1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_00FF, 1'b1, 32'h0);
        access("f_sw100",  1'b1, 2'b10, 1'b0, 32'h104, 32'h1111_1111, 1'b1, 32'h0);
        access("f_sz11l",  1'b0, 2'b11, 1'b0, 32'h004, 32'h0,         1'b1, 32'h0);
        access("f_sz11s",  1'b1, 2'b11, 1'b0, 32'h000, 32'hDEAD_BEEF, 1'b1, 32'h0);
        access("f_lw000",  1'b0, 2'b10, 1'b0, 32'h000, 32'h0,         1'b0, 32'h0000_0000);
        access("f_lw004",  1'b0, 2'b10, 1'b0, 32'h004, 32'h0,         1'b0, 32'hCA80_BABE);

        // Idle cycle: outputs quiet
        @(negedge clk);
        chk("idle.rvalid", {31'b0, bus.rvalid}, 32'd0);
        chk("idle.err",    {31'b0, bus.err},    32'd0);
        chk("idle.data",   bus.read_data,       32'd0);

        // Streaming: 4 stores then 4 loads, one per cycle
        for (int i = 0; i < 4; i++)
            access("st_sw", 1'b1, 2'b10, 1'b0, 32'h010 + 32'(4*i),
                   32'hA5A5_0000 + 32'(i * 32'h0101), 1'b0, 32'h0);
        for (int i = 0; i < 4; i++)
            access("st_lw", 1'b0, 2'b10, 1'b0, 32'h010 + 32'(4*i), 32'h0,
                   1'b0, 32'hA5A5_0000 + 32'(i * 32'h0101));

        // Reset in the cycle after a load is accepted
        access("rr_lw004", 1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 1'b0, 32'hCA80_BABE);
        startin = 1'b0;
        @(negedge clk);
        startin = 1'b1;
        chk("rr.rvalid_drop", {31'b0, bus.rvalid}, 32'd0);
        chk("rr.data_drop",   bus.read_data,       32'd0);
        init_phase("rinit");
        access("rr_lw004z", 1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 1'b0, 32'h0000_0000);
        access("rr_lw010z", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 1'b0, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_data_mem.md
MIPS_DATA_MEM -- requirements
Module: mips_data_mem

Interface
REQ-001 Parameter DEPTH, default 64, memory size in 32-bit words; power of two, 4..4096.
REQ-002 Parameter AW, default $clog2(DEPTH), word-index width, derived, not overridden.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 startin  in  1  reset; synchronous, active-low.
REQ-005 req  in  1  access request, sampled on clk.
REQ-006 we  in  1  1 = store, 0 = load.
REQ-007 size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 sign_ext  in  1  loads only: 1 = sign-extend sub-word result, 0 = zero-extend.
REQ-009 address  in  32  byte address.
REQ-010 write_data  in  32  store data, right-aligned: byte uses [7:0], halfword uses [15:0].
REQ-011 ready  out  1  block accepts a request this cycle.
REQ-012 rvalid  out  1  one-cycle response pulse for each accepted request.
REQ-013 read_data  out  32  load result, valid only while rvalid=1.
REQ-014 err  out  1  faulty request flag, valid only while rvalid=1.

Function
REQ-015 The FSM SHALL have two states: INIT and RUN.
REQ-016 INIT SHALL clear one word per cycle, indices 0..DEPTH-1, and SHALL hold ready=0 throughout.
REQ-017 INIT SHALL last exactly DEPTH cycles, then move to RUN.
REQ-018 In RUN, ready SHALL be 1 every cycle; one request accepted per cycle; no back-pressure.
REQ-019 A request SHALL be accepted when req=1 and ready=1; req during INIT SHALL be ignored with no response.
REQ-020 An accepted request in cycle N SHALL produce rvalid=1 in cycle N+1 only; back-to-back requests SHALL give back-to-back rvalid pulses.
REQ-021 Word index SHALL be address[AW+1:2]; byte lane k = address[1:0] SHALL map to bits [8k+7:8k] (little-endian lanes).
REQ-022 The request SHALL be faulty when any of these holds:
- address >= 4*DEPTH;
- size=11;
- size=01 with address[0]=1;
- size=10 with address[1:0]!=00.
REQ-023 A faulty request SHALL give err=1 and read_data=0 with its rvalid, and SHALL NOT modify memory.
REQ-024 A good store SHALL write only the addressed byte(s) at the clk edge ending cycle N.
- Halfword writes the lanes at address[1] selection.
- rvalid=1, err=0, read_data=0 in cycle N+1.
REQ-025 A good load SHALL return in cycle N+1 the addressed byte/halfword/word, right-aligned, extended per sign_ext.
- sign_ext SHALL be ignored for word loads.
REQ-026 A load in cycle N+1 to the address stored in cycle N SHALL return the new data.
REQ-027 When rvalid=0, read_data and err SHALL be 0.

Reset
REQ-028 While startin=0 at a clk edge:
- state SHALL become INIT and the clear counter 0;
- ready, rvalid, err and read_data SHALL be 0.
REQ-029 Reset mid-operation SHALL drop any pending response and SHALL rerun the full INIT clear after startin returns to 1.
REQ-030 Memory contents SHALL be defined (all zero) only after INIT completes.

Verification (DEPTH=64)
REQ-031 Init: release startin and hold req=1.
- ready=0 and no rvalid for 64 cycles;
- ready=1 on cycle 65;
- a load of 0x0FC then returns 0x00000000.
REQ-032 Word: store 0xCAFEBABE to 0x004, then load word from 0x004.
- read_data=0xCAFEBABE, err=0, one cycle after the load is accepted.
REQ-033 Sub-word: after REQ-032, store byte 0x80 to 0x006, then load word from 0x004.
- Word load returns 0xCA80BABE.
- lb 0x006 returns 0xFFFFFF80; lbu 0x006 returns 0x00000080.
- lh 0x006 returns 0xFFFFCA80; lhu 0x004 returns 0x0000BABE.
REQ-034 Faults: each of the following gives rvalid=1, err=1, read_data=0:
- word store to 0x002;
- halfword load from 0x005;
- any access to 0x100;
- size=11.
- A load of 0x000 afterwards confirms memory unchanged.
REQ-035 Streaming: issue 4 consecutive stores then 4 loads, addresses 0x010..0x01C, one request per cycle.
- 8 consecutive rvalid pulses.
- The loads return the stored data in order.
REQ-036 Reset mid-run: assert startin=0 for 1 cycle in the cycle after a load is accepted.
- No rvalid in the following cycle.
- ready=0 for 64 cycles.
- Previously written 0x004 reads 0x00000000.
